// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: round-robin two-requester front end for the GPU's single
// Avalon-MM master, with grant lock and a waitrequest watchdog.
module gpu_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                r0_req,
  input  logic                r1_req,
  input  logic                r0_write,
  input  logic                r1_write,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r0_be,
  input  logic [DATA_W/8-1:0] r1_be,
  input  logic                r0_lock,
  input  logic                r1_lock,
  output logic                r0_ack,
  output logic                r1_ack,
  output logic                r0_err,
  output logic                r1_err,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest,
  output logic                arb_busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t          state;
  logic            owner;
  logic            last_grant;
  logic            lock_hold;
  logic [WD_W-1:0] wd;

  logic              gnt_vld;
  logic              gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              sel_write;
  logic              sel_lock;
  logic              held_req;

  // Pick the next owner: held lock first, then lone request, then round-robin.
  always_comb begin
    gnt_vld  = r0_req | r1_req;
    held_req = last_grant ? r1_req : r0_req;
    gnt      = 1'b0;
    if (lock_hold && held_req) begin
      gnt = last_grant;
    end else if (r0_req && r1_req) begin
      gnt = ~last_grant;
    end else if (r1_req) begin
      gnt = 1'b1;
    end
    sel_addr  = gnt ? r1_addr  : r0_addr;
    sel_wdata = gnt ? r1_wdata : r0_wdata;
    sel_be    = gnt ? r1_be    : r0_be;
    sel_write = gnt ? r1_write : r0_write;
    sel_lock  = gnt ? r1_lock  : r0_lock;
  end

  // Arbiter FSM with registered bus command, response and watchdog.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      lock_hold    <= 1'b0;
      wd           <= '0;
      r0_ack       <= 1'b0;
      r1_ack       <= 1'b0;
      r0_err       <= 1'b0;
      r1_err       <= 1'b0;
      rdata        <= '0;
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      arb_busy     <= 1'b0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            m_address    <= sel_addr;
            m_writedata  <= sel_wdata;
            m_byteenable <= sel_be;
            m_write      <= sel_write;
            m_read       <= ~sel_write;
            owner        <= gnt;
            last_grant   <= gnt;
            lock_hold    <= sel_lock;
            wd           <= '0;
            arb_busy     <= 1'b1;
            state        <= ISSUE;
          end else begin
            lock_hold <= 1'b0;
          end
        end
        ISSUE: begin
          if (!m_waitrequest) begin
            if (m_read) rdata <= m_readdata;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            r0_ack  <= ~owner;
            r1_ack  <= owner;
            state   <= RESP;
          end else if (wd == WD_LAST) begin
            rdata   <= '0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            r0_ack  <= ~owner;
            r1_ack  <= owner;
            r0_err  <= ~owner;
            r1_err  <= owner;
            state   <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
